// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   MEM_AW_DEFAULT : default byte-address width of the attached data RAM
//   F3_*           : RV32I funct3 encodings for loads and stores
//   lsu_state_t    : FSM state encoding (also exported on the debug port)
//   funct3_valid   : legal funct3 check for a load or a store
//   misaligned     : natural-alignment check for the access size
package lsu_pkg;

    localparam int MEM_AW_DEFAULT = 10;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_t;

    function automatic logic funct3_valid(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 <= F3_SW);
        else
            return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    endfunction

    // funct3[1:0] gives the access size for both loads and stores
    // (LBU/LHU share the low bits of LB/LH): 0 byte, 1 half, 2 word.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'd1:    return a[0];
            2'd2:    return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte/halfword lane logic for the load/store unit.
//   word     in  32 : aligned word read from RAM
//   addr     in  2  : byte offset within the word
//   funct3   in  3  : access type (load or store encoding)
//   wdata    in  32 : store data (low byte/half used for SB/SH)
//   load_val out 32 : extracted and extended load result
//   merged   out 32 : word with the addressed byte/half replaced by wdata
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_val = 32'd0;
        case (funct3)
            F3_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            F3_LW:   load_val = word;
            F3_LBU:  load_val = {24'd0, byte_sel};
            F3_LHU:  load_val = {16'd0, half_sel};
            default: load_val = 32'd0;
        endcase
    end

    always_comb begin
        merged = word;
        case (funct3)
            F3_SB:   merged[{addr, 3'b000} +: 8] = wdata[7:0];
            F3_SH:   merged = addr[1] ? {wdata[15:0], word[15:0]}
                                      : {word[31:16], wdata[15:0]};
            F3_SW:   merged = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a byte-addressed little-endian RAM
// with one-edge read latency. Sub-word stores are read-modify-write.
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid / req_ready     : request handshake, ready only in IDLE
//   req_we/funct3/addr/wdata  : request payload, captured on acceptance
//   resp_valid/err/rdata      : one-cycle completion pulse
//   mem_enable/rw/addr/datain : RAM command (word-aligned address only)
//   mem_dataout               : RAM read data, valid the cycle after RD
//   state_dbg                 : current FSM state
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; resp_valid is high for exactly one cycle per
// accepted request and the next request may be accepted the cycle after.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_dataout,
    output logic [31:0]       mem_datain,
    output logic [2:0]        state_dbg
);

    lsu_state_t state, state_nx;

    logic              r_we;
    logic [2:0]        r_f3;
    logic [MEM_AW-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_merged;

    logic              accept;
    logic              req_bad;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign accept    = req_valid && req_ready;
    assign state_dbg = state;

    always_comb begin
        req_bad = (|req_addr[31:MEM_AW])
               || misaligned(req_funct3, req_addr[1:0])
               || !funct3_valid(req_we, req_funct3);
    end

    lsu_align u_align (
        .word     (mem_dataout),
        .addr     (r_addr[1:0]),
        .funct3   (r_f3),
        .wdata    (r_wdata),
        .load_val (load_val),
        .merged   (merged)
    );

    // State and request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            r_we     <= 1'b0;
            r_f3     <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_merged <= 32'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr[MEM_AW-1:0];
                r_wdata <= req_wdata;
            end
            if (state == ST_CAP && r_we)
                r_merged <= merged;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad)
                        state_nx = ST_ERR;
                    else if (req_we && req_funct3 == F3_SW)
                        state_nx = ST_WR;
                    else
                        state_nx = ST_RD;
                end
            end
            ST_RD:   state_nx = ST_CAP;
            ST_CAP:  state_nx = r_we ? ST_WR : ST_IDLE;
            ST_WR:   state_nx = ST_IDLE;
            ST_ERR:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs; everything is held quiet while rst is high so a reset
    // landing in CAP/WR cannot leak a response or a write.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        mem_enable = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_datain = 32'd0;
        if (!rst) begin
            case (state)
                ST_IDLE: req_ready = 1'b1;
                ST_RD: begin
                    mem_enable = 1'b1;
                    mem_addr   = {r_addr[MEM_AW-1:2], 2'b00};
                end
                ST_CAP: begin
                    if (!r_we) begin
                        resp_valid = 1'b1;
                        resp_rdata = load_val;
                    end
                end
                ST_WR: begin
                    mem_enable = 1'b1;
                    mem_rw     = 1'b1;
                    mem_addr   = {r_addr[MEM_AW-1:2], 2'b00};
                    mem_datain = (r_f3 == F3_SW) ? r_wdata : r_merged;
                    resp_valid = 1'b1;
                end
                ST_ERR: begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, byte-address width of the attached data RAM (1024 bytes).
REQ-002 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid in 1, req_ready out 1: core-side request handshake.
REQ-005 SHALL have ports req_we in 1 (1=store), req_funct3 in 3 (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW), req_addr in 32, req_wdata in 32.
REQ-006 SHALL have ports resp_valid out 1, resp_err out 1, resp_rdata out 32: one-cycle completion pulse.
REQ-007 SHALL have ports mem_enable out 1, mem_rw out 1 (0=read, 1=write), mem_addr out MEM_AW, mem_datain out 32, mem_dataout in 32, towards the byte-addressed little-endian RAM.

Function
REQ-008 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-009 SHALL register we, funct3, addr, wdata on acceptance; later changes on req_* SHALL have no effect.
REQ-010 SHALL use states IDLE, RD, CAP, WR, ERR.
REQ-011 SHALL on acceptance go to ERR if: req_addr[31:MEM_AW] nonzero; halfword with addr[0]=1; word with addr[1:0]!=0; funct3 invalid (loads 3,6,7; stores >2).
REQ-012 SHALL otherwise go to WR for SW, else to RD.
REQ-013 SHALL drive mem_addr = {addr[MEM_AW-1:2],2'b00} whenever mem_enable=1; never an unaligned address.
REQ-014 RD: mem_enable=1, mem_rw=0 for exactly one cycle; next state CAP.
REQ-015 CAP: mem_dataout is valid (RAM read latency one edge); load: resp_valid=1, resp_rdata = selected byte/half per addr[1:0], sign-extended for LB/LH, zero-extended for LBU/LHU, unmodified for LW; next IDLE.
REQ-016 CAP for SB/SH: resp_valid=0; SHALL register merged word = mem_dataout with only the addressed byte/half replaced by wdata[7:0]/[15:0]; next WR.
REQ-017 WR: mem_enable=1, mem_rw=1, mem_datain = wdata (SW) or merged word (SB/SH), resp_valid=1, resp_rdata=0; next IDLE.
REQ-018 ERR: resp_valid=1, resp_err=1, resp_rdata=0, mem_enable=0; next IDLE.
REQ-019 resp_err SHALL be 0 whenever resp_valid=1 outside ERR; mem_enable SHALL be 0 in IDLE, CAP, ERR.
REQ-020 Latency from acceptance edge to resp_valid cycle: SW 1 cycle, load 2 cycles, SB/SH 3 cycles, error 1 cycle.
REQ-021 Back-to-back: new request acceptable in the cycle after resp_valid; no overlap of outstanding accesses.

Reset
REQ-022 On rst=1 at a rising edge: state=IDLE, request and merge registers cleared to 0, regardless of current state.
REQ-023 During and after reset: resp_valid=0, resp_err=0, resp_rdata=0, mem_enable=0, mem_rw=0, mem_addr=0, mem_datain=0, req_ready=1 after reset deasserts.
REQ-024 Reset mid-operation (RD/CAP/WR) SHALL abandon the access with no response and no further memory write.

Structure
REQ-025 Shared package lsu_pkg SHALL hold funct3 constants, state enum, MEM_AW default.
REQ-026 Byte/half extraction and merge SHALL be one combinational sub-module lsu_align (inputs word, addr[1:0], funct3, wdata; outputs load value, merged word).

Verification
REQ-027 RAM word@0x010=0x8899AABB; LB addr 0x013 -> resp_rdata 0xFFFFFF88 two cycles after acceptance.
REQ-028 Same word; LHU addr 0x012 -> 0x00008899; LW 0x010 -> 0x8899AABB.
REQ-029 Word@0x020=0x11223344; SB addr 0x021 wdata 0x000000EE -> read, then write 0x1122EE44 to mem_addr 0x020, resp_valid 3 cycles after acceptance.
REQ-030 LW addr 0x006 -> resp_err=1 one cycle after acceptance, mem_enable never asserted; LW addr 0x400 -> resp_err=1.
REQ-031 SW 0x3FC wdata 0xDEADBEEF then LW 0x3FC back-to-back -> 0xDEADBEEF; mem_addr never exceeds 0x3FC.
REQ-032 Assert rst during CAP of SH -> no WR cycle, no resp_valid, req_ready=1 after reset.
